atm_pin_keypad: RTL and testbench
=================================

Name: atm_pin_keypad

Overview:
- Upstream stage of the ATM controller FSM. Collects keypad keystrokes into a 4-digit BCD PIN and presents it on a 16-bit bus that drives the controller's pin_input.
- Provides a one-cycle pin_ready strobe, digit-count feedback for masked display, editing keys, cancel, and an inactivity timeout.
- Runs only while the controller holds enable high, i.e. while it is in PIN entry.

Parameters:
- TIMEOUT_CYCLES, 1000, cycles without a keystroke before an entry in progress is abandoned (must be >= 2).
- TIMER_W, 16, width of the inactivity counter; 2^TIMER_W must exceed TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  controller requests PIN entry; level
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0x0-0x9 digit, 0xA clear, 0xB backspace, 0xC enter, 0xD cancel, 0xE/0xF reserved
- pin_input  out  16  assembled PIN, first digit in [15:12], last in [3:0]
- pin_ready  out  1  one-cycle strobe, pin_input valid
- digit_count  out  3  digits currently entered, 0-4
- key_error  out  1  one-cycle strobe, key rejected
- cancel  out  1  one-cycle strobe, user cancelled
- timeout  out  1  one-cycle strobe, inactivity timeout
- busy  out  1  high in COLLECT

Behaviour:
- Reset (asynchronous, any state): state IDLE; shift register 0; timer 0. All outputs are 0: pin_input, pin_ready, digit_count, key_error, cancel, timeout and busy.
- All outputs are registered. A key sampled at edge N produces its effect (strobes, count, pin_input) after edge N, so strobes are high for exactly cycle N+1.
- States:
  - IDLE: while enable=0, keys are ignored and nothing changes. On enable=1, go to COLLECT and clear the shift register, digit_count and timer.
  - COLLECT: busy=1.
    - Digit with digit_count<4: shift_reg <= {shift_reg[11:0], key_code}; digit_count+1.
    - Digit with digit_count==4: ignored, key_error pulse.
    - Backspace: if digit_count>0, shift_reg <= {4'h0, shift_reg[15:4]} and digit_count-1; otherwise key_error.
    - Clear: shift_reg=0, digit_count=0; never an error.
    - Enter with digit_count==4: pin_input <= shift_reg, pin_ready pulse, go to DONE.
    - Enter with digit_count<4: key_error, remain in COLLECT, buffer kept.
    - Cancel: cancel pulse, clear the buffer, go to IDLE.
    - Reserved code: key_error, no other effect.
  - DONE: hold pin_input stable and ignore keys. When enable=0, clear pin_input to 0 and go to IDLE.
- Timer:
  - Counts only in COLLECT and resets to 0 on every sampled key_valid, whether accepted or rejected.
  - When the timer reaches TIMEOUT_CYCLES-1 with no key that cycle: timeout pulse, clear the buffer, go to IDLE.
  - A key arriving on that same cycle wins; no timeout.
- enable dropping in COLLECT: go to IDLE, clear the buffer, no strobe.
- enable dropping on the same cycle as a key: the enable drop wins and the key is discarded.
- enable must drop before a retry. After DONE or a cancel/timeout return to IDLE, a new entry starts only after enable is deasserted and reasserted.
  - Implement with a registered enable: entry to COLLECT requires enable=1 and prev_enable=0.
- key_valid with no state change (IDLE/DONE): no strobes.
- At most one of pin_ready, key_error, cancel and timeout is high in any cycle.
- Security: the shift register is cleared on every exit from COLLECT; pin_input is zero outside DONE.

Test Plan:
- Entry: reset, enable rising edge, keys 1,2,3,4, then enter. Expect digit_count to step 1..4; one cycle after enter, pin_ready=1 for exactly one cycle, pin_input=16'h1234 and held until enable=0, then 16'h0000.
- Editing: keys 5,6,backspace,7,8,9, then enter. Expect pin_input=16'h5789. Then a fifth digit before enter (keys 1,2,3,4,5): key_error on the 5; enter gives 16'h1234.
- Short enter: keys 9,9,9, enter. Expect key_error pulse, no pin_ready, digit_count stays 3. Key 0 then enter gives 16'h9990.
- Timeout: with TIMEOUT_CYCLES=8, enable and enter key 3, then idle. Expect timeout pulse 8 cycles after the key, digit_count=0, busy=0. Keys while enable is held give no effect.
- Cancel and reset: keys 1,2 then cancel gives a cancel pulse and returns to IDLE. Separately, assert rst_n=0 mid-entry (count 3): all outputs go to 0 immediately, without waiting for a clock edge.
- Simultaneous: a key_valid on the timeout cycle gives no timeout and the key is accepted. enable falling on the same cycle as enter gives no pin_ready and a return to IDLE.

Source files
------------

// File: rtl/atm_pin_keypad.sv
// Keypad front end for the ATM controller: assembles four BCD digits into a PIN,
// with edit keys, cancel and an inactivity timeout. All outputs are registered.
module atm_pin_keypad #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_code,
    output logic [15:0] o_pin_input,
    output logic        o_pin_ready,
    output logic [2:0]  o_digit_count,
    output logic        o_key_error,
    output logic        o_cancel,
    output logic        o_timeout,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [3:0]         K_CLEAR    = 4'hA;
    localparam logic [3:0]         K_BACK     = 4'hB;
    localparam logic [3:0]         K_ENTER    = 4'hC;
    localparam logic [3:0]         K_CANCEL   = 4'hD;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    state_t             r_state;
    logic [15:0]        r_shift;
    logic [2:0]         r_count;
    logic [TIMER_W-1:0] r_timer;
    logic               r_prev_en;
    logic [15:0]        r_pin_input;
    logic               r_pin_ready;
    logic               r_key_error;
    logic               r_cancel;
    logic               r_timeout;
    logic               r_busy;

    logic w_is_digit;
    logic w_full;

    assign w_is_digit = (i_key_code <= 4'h9);
    assign w_full     = (r_count == 3'd4);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= 16'h0000;
            r_count     <= 3'd0;
            r_timer     <= '0;
            r_prev_en   <= 1'b0;
            r_pin_input <= 16'h0000;
            r_pin_ready <= 1'b0;
            r_key_error <= 1'b0;
            r_cancel    <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_prev_en   <= i_enable;
            r_pin_ready <= 1'b0;
            r_key_error <= 1'b0;
            r_cancel    <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Only a fresh rising edge of enable starts an entry.
                    if (i_enable && !r_prev_en) begin
                        r_state <= S_COLLECT;
                        r_busy  <= 1'b1;
                        r_shift <= 16'h0000;
                        r_count <= 3'd0;
                        r_timer <= '0;
                    end
                end
                S_COLLECT: begin
                    if (!i_enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_shift <= 16'h0000;
                        r_count <= 3'd0;
                        r_timer <= '0;
                    end else if (i_key_valid) begin
                        r_timer <= '0;
                        if (w_is_digit) begin
                            if (!w_full) begin
                                r_shift <= {r_shift[11:0], i_key_code};
                                r_count <= r_count + 3'd1;
                            end else begin
                                r_key_error <= 1'b1;
                            end
                        end else begin
                            case (i_key_code)
                                K_CLEAR: begin
                                    r_shift <= 16'h0000;
                                    r_count <= 3'd0;
                                end
                                K_BACK: begin
                                    if (r_count != 3'd0) begin
                                        r_shift <= {4'h0, r_shift[15:4]};
                                        r_count <= r_count - 3'd1;
                                    end else begin
                                        r_key_error <= 1'b1;
                                    end
                                end
                                K_ENTER: begin
                                    if (w_full) begin
                                        r_pin_input <= r_shift;
                                        r_pin_ready <= 1'b1;
                                        r_state     <= S_DONE;
                                        r_busy      <= 1'b0;
                                        r_shift     <= 16'h0000;
                                        r_count     <= 3'd0;
                                    end else begin
                                        r_key_error <= 1'b1;
                                    end
                                end
                                K_CANCEL: begin
                                    r_cancel <= 1'b1;
                                    r_state  <= S_IDLE;
                                    r_busy   <= 1'b0;
                                    r_shift  <= 16'h0000;
                                    r_count  <= 3'd0;
                                end
                                default: r_key_error <= 1'b1;
                            endcase
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_shift   <= 16'h0000;
                        r_count   <= 3'd0;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end
                S_DONE: begin
                    if (!i_enable) begin
                        r_pin_input <= 16'h0000;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pin_input   = r_pin_input;
    assign o_pin_ready   = r_pin_ready;
    assign o_digit_count = r_count;
    assign o_key_error   = r_key_error;
    assign o_cancel      = r_cancel;
    assign o_timeout     = r_timeout;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_atm_pin_keypad.sv
// Scoreboarded bench for atm_pin_keypad: expected strobes are queued by the
// stimulus thread and matched by a monitor whenever the DUT raises a strobe.
module tb_atm_pin_keypad;

    localparam int TO = 8;

    localparam logic [3:0] E_READY  = 4'b1000;
    localparam logic [3:0] E_ERROR  = 4'b0100;
    localparam logic [3:0] E_CANCEL = 4'b0010;
    localparam logic [3:0] E_TMO    = 4'b0001;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] pin;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] pin_input;
    logic        pin_ready;
    logic [2:0]  digit_count;
    logic        key_error;
    logic        cancel;
    logic        timeout;
    logic        busy;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    atm_pin_keypad #(.TIMEOUT_CYCLES(TO), .TIMER_W(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_key_valid   (key_valid),
        .i_key_code    (key_code),
        .o_pin_input   (pin_input),
        .o_pin_ready   (pin_ready),
        .o_digit_count (digit_count),
        .o_key_error   (key_error),
        .o_cancel      (cancel),
        .o_timeout     (timeout),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: any strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [3:0] act;
        exp_t       e;
        act = {pin_ready, key_error, cancel, timeout};
        if (rst_n && act != 4'b0000) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got strobes=%b pin=%h, required none", act, pin_input);
            end else begin
                e = sb_q.pop_front();
                if (act != e.kind || pin_input != e.pin) begin
                    bad++;
                    $display("FAIL strobe_match: got strobes=%b pin=%h, required strobes=%b pin=%h",
                             act, pin_input, e.kind, e.pin);
                end else begin
                    $display("txn ok: strobes=%b pin=%h", act, pin_input);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("check ok: %s = %h", name, act);
        end
    endtask

    task automatic expect_ev(input logic [3:0] kind, input logic [15:0] pin);
        exp_t e;
        e.kind = kind;
        e.pin  = pin;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick(1);
        key_valid = 1'b0;
    endtask

    task automatic start_entry();
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        #12;
        chk("reset_pin_input", pin_input, 16'h0000);
        chk("reset_strobes", {12'h0, pin_ready, key_error, cancel, timeout}, 16'h0000);
        chk("reset_count_busy", {12'h0, digit_count, busy}, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        tick(2);

        // Basic entry 1,2,3,4 enter
        start_entry();
        chk("entry_busy", {15'h0, busy}, 16'h0001);
        for (int i = 1; i <= 4; i++) begin
            press(4'(i));
            chk("entry_count", {13'h0, digit_count}, 16'(i));
        end
        expect_ev(E_READY, 16'h1234);
        press(4'hC);
        chk("entry_pin", pin_input, 16'h1234);
        tick(1);
        chk("entry_ready_one_cycle", {15'h0, pin_ready}, 16'h0000);
        press(4'h5);
        tick(2);
        chk("done_hold_pin", pin_input, 16'h1234);
        enable = 1'b0;
        tick(1);
        chk("done_clear_pin", pin_input, 16'h0000);

        // Editing: backspace on empty errors, then 5,6,BS,7,8,9
        start_entry();
        expect_ev(E_ERROR, 16'h0000);
        press(4'hB);
        press(4'h5); press(4'h6); press(4'hB);
        chk("bs_count", {13'h0, digit_count}, 16'h0001);
        press(4'h7); press(4'h8); press(4'h9);
        expect_ev(E_READY, 16'h5789);
        press(4'hC);
        start_entry();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        expect_ev(E_ERROR, 16'h0000);
        press(4'h5);
        chk("full_count", {13'h0, digit_count}, 16'h0004);
        expect_ev(E_READY, 16'h1234);
        press(4'hC);

        // Clear, reserved code, short enter
        start_entry();
        press(4'h9); press(4'h9); press(4'hA);
        chk("clear_count", {13'h0, digit_count}, 16'h0000);
        expect_ev(E_ERROR, 16'h0000);
        press(4'hE);
        press(4'h9); press(4'h9); press(4'h9);
        expect_ev(E_ERROR, 16'h0000);
        press(4'hC);
        chk("short_count", {13'h0, digit_count}, 16'h0003);
        chk("short_busy", {15'h0, busy}, 16'h0001);
        press(4'h0);
        expect_ev(E_READY, 16'h9990);
        press(4'hC);

        // Timeout: strobe exactly TO cycles after the last key
        start_entry();
        press(4'h3);
        tick(TO - 1);
        chk("pre_timeout", {15'h0, timeout}, 16'h0000);
        chk("pre_timeout_busy", {15'h0, busy}, 16'h0001);
        expect_ev(E_TMO, 16'h0000);
        tick(1);
        chk("timeout_state", {12'h0, digit_count, busy}, 16'h0000);
        press(4'h4);
        chk("after_timeout_ignored", {12'h0, digit_count, busy}, 16'h0000);

        // Cancel
        start_entry();
        press(4'h1); press(4'h2);
        expect_ev(E_CANCEL, 16'h0000);
        press(4'hD);
        chk("cancel_state", {12'h0, digit_count, busy}, 16'h0000);

        // Asynchronous reset mid-entry
        start_entry();
        press(4'h1); press(4'h2); press(4'h3);
        chk("pre_reset_count", {13'h0, digit_count}, 16'h0003);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_reset", {12'h0, digit_count, busy}, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        tick(1);

        // Key on the timeout cycle wins
        start_entry();
        press(4'h1);
        tick(TO - 1);
        press(4'h2);
        chk("key_beats_timeout", {12'h0, digit_count, busy}, 16'h0005);
        press(4'h3); press(4'h4);
        // enable drop together with enter
        key_valid = 1'b1; key_code = 4'hC; enable = 1'b0;
        tick(1);
        key_valid = 1'b0;
        chk("drop_with_enter", {pin_input[14:0], busy}, 16'h0000);
        chk("drop_count", {13'h0, digit_count}, 16'h0000);

        tick(3);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL missing_strobes: got %0d pending, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
